// File: rtl/audio_bridge_pkg.sv
// Shared types for the SPI-sample to UART bridge.
// Provides the bridge FSM state encoding and the sample width.
// No ports; imported by sample_uart_bridge.
package audio_bridge_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SEND
  } bridge_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count and a flush input.
// Ports: push_i/wdata_i write side, pop_i/rdata_o read side (rdata_o shows the head
// combinationally), full_o/empty_o/level_o status, flush_i drops all contents.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push is about to overwrite.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign level_o = wptr_q - rptr_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      wptr_d = wptr_q + PW'(1);
    end
    // Flush discards everything already stored; a same-cycle push survives it.
    if (flush_i) begin
      rptr_d = wptr_q;
    end else if (do_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/sample_uart_bridge.sv
// Buffers 8-bit samples sliced from SPI read words and feeds them to a UART
// transmitter one byte per busy handshake; also holds the latest sample for PWM.
// Ports: clk_in/rst_n_in, enable_in (stream enable, low flushes), clear_in (clears
// overflow), spi_data_in/spi_valid_in (capture), uart_busy_in/uart_data_out/
// uart_trigger_out (UART side), sample_out, level_out, overflow_out (status).
module sample_uart_bridge
  import audio_bridge_pkg::*;
#(
  parameter int SRC_WIDTH    = 17,
  parameter int SAMPLE_LSB   = 2,
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   enable_in,
  input  logic                   clear_in,
  input  logic [SRC_WIDTH-1:0]   spi_data_in,
  input  logic                   spi_valid_in,
  input  logic                   uart_busy_in,
  output logic [SAMPLE_W-1:0]    uart_data_out,
  output logic                   uart_trigger_out,
  output logic [SAMPLE_W-1:0]    sample_out,
  output logic [$clog2(DEPTH):0] level_out,
  output logic                   overflow_out
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  bridge_state_t       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                trig_q, trig_d;
  logic                overflow_q, overflow_d;

  logic [SAMPLE_W-1:0] slice;
  logic [SAMPLE_W-1:0] head;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                spi_unused_bits;

  assign slice = spi_data_in[SAMPLE_LSB +: SAMPLE_W];
  assign push  = spi_valid_in && enable_in;
  // Only the sample slice of the SPI word is consumed.
  assign spi_unused_bits = ^spi_data_in;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (!enable_in),
    .wdata_i (slice),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    trig_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && enable_in && !uart_busy_in) begin
          pop     = 1'b1;
          trig_d  = 1'b1;
          data_d  = head;
          cnt_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        // If the transmitter never acknowledges, treat the byte as sent.
        if (uart_busy_in) begin
          state_d = SEND;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND: begin
        if (!uart_busy_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture runs regardless of enable so the PWM path always sees fresh audio.
  assign sample_d = spi_valid_in ? slice : sample_q;

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_in) begin
      overflow_d = 1'b0;
    end
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      trig_q     <= 1'b0;
      sample_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      trig_q     <= trig_d;
      sample_q   <= sample_d;
      overflow_q <= overflow_d;
    end
  end

  assign uart_data_out    = data_q;
  assign uart_trigger_out = trig_q;
  assign sample_out       = sample_q;
  assign overflow_out     = overflow_q;

endmodule

// File: tb/tb_sample_uart_bridge.sv
module tb_sample_uart_bridge;

  localparam int SRC_WIDTH    = 17;
  localparam int SAMPLE_LSB   = 2;
  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 clear = 1'b0;
  logic [SRC_WIDTH-1:0] spi_data = '0;
  logic                 spi_valid = 1'b0;
  logic                 uart_busy;
  logic [7:0]           uart_data;
  logic                 trig;
  logic [7:0]           sample;
  logic [4:0]           level;
  logic                 overflow;

  // UART model and bench state
  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
  bit         uart_mute = 1'b0;
  int         uart_len = 3;
  int         busy_cnt = 0;
  int         delay_cnt = 0;
  bit         prev_trig = 1'b0;

  logic [7:0] exp_q[$];
  int         trig_cyc[$];
  int         trig_count = 0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  assign uart_busy = force_busy | model_busy;

  sample_uart_bridge #(
    .SRC_WIDTH    (SRC_WIDTH),
    .SAMPLE_LSB   (SAMPLE_LSB),
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .enable_in        (enable),
    .clear_in         (clear),
    .spi_data_in      (spi_data),
    .spi_valid_in     (spi_valid),
    .uart_busy_in     (uart_busy),
    .uart_data_out    (uart_data),
    .uart_trigger_out (trig),
    .sample_out       (sample),
    .level_out        (level),
    .overflow_out     (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] slice_of(input logic [SRC_WIDTH-1:0] d);
    return d[SAMPLE_LSB +: 8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [SRC_WIDTH-1:0] d, input bit accept);
    spi_data  = d;
    spi_valid = 1'b1;
    step();
    spi_valid = 1'b0;
    if (accept) exp_q.push_back(slice_of(d));
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && level == 0) break;
      step();
    end
    check(name, exp_q.size(), 0);
    repeat (3) step();
    for (int i = 0; i < budget && uart_busy; i++) step();
    repeat (3) step();
  endtask

  // UART transmitter model: busy rises one cycle after a trigger and lasts uart_len cycles.
  initial forever begin
    @(negedge clk);
    if (busy_cnt > 0) busy_cnt--;
    if (delay_cnt > 0) begin
      delay_cnt--;
      if (delay_cnt == 0) busy_cnt = uart_len;
    end
    if (rst_n && trig && !uart_mute) delay_cnt = 1;
    model_busy = (busy_cnt > 0);
  end

  // Monitor: every trigger must carry the oldest outstanding expected byte.
  initial forever begin
    @(negedge clk);
    if (rst_n && trig) begin
      check("trig_single_cycle", prev_trig, 1'b0);
      trig_count++;
      trig_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_trigger: byte %0h sent, expected no trigger", uart_data);
      end else begin
        check("uart_data", uart_data, exp_q.pop_front());
      end
    end
    prev_trig = rst_n && trig;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SRC_WIDTH-1:0] d;
    int t0, t1, sp;

    // Reset state
    repeat (3) step();
    check("rst_uart_data", uart_data, 0);
    check("rst_trigger", trig, 0);
    check("rst_sample", sample, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    step();

    // Single sample
    t0 = trig_count;
    push(17'h003FC, 1'b1);
    check("single_sample", sample, 8'hFF);
    check("single_level", level, 1);
    wait_idle("single_drain", 200);
    check("single_trig_count", trig_count - t0, 1);
    check("single_level_end", level, 0);

    // Randomized paced traffic with varying UART frame lengths
    for (int n = 0; n < 40; n++) begin
      uart_len = $urandom_range(1, 4);
      d = SRC_WIDTH'($urandom);
      push(d, 1'b1);
      check("rand_sample", sample, slice_of(d));
      repeat ($urandom_range(10, 20)) step();
    end
    wait_idle("rand_drain", 300);
    check("rand_no_overflow", overflow, 0);

    // Overflow with busy held high
    uart_len   = 3;
    force_busy = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      d = SRC_WIDTH'($urandom);
      push(d, i < DEPTH);
      if (i == DEPTH - 1) check("ovf_not_yet", overflow, 0);
    end
    check("ovf_level", level, DEPTH);
    check("ovf_flag", overflow, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("ovf_clear", overflow, 0);
    check("ovf_level_kept", level, DEPTH);

    // Push and pop in the same cycle while full
    d          = SRC_WIDTH'($urandom);
    spi_data   = d;
    spi_valid  = 1'b1;
    force_busy = 1'b0;
    step();
    spi_valid  = 1'b0;
    exp_q.push_back(slice_of(d));
    check("pushpop_level", level, DEPTH);
    check("pushpop_no_ovf", overflow, 0);
    wait_idle("ovf_drain", 1000);

    // Overflow coinciding with clear: set wins
    force_busy = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) push(SRC_WIDTH'($urandom), 1'b1);
    spi_data  = SRC_WIDTH'($urandom);
    spi_valid = 1'b1;
    clear     = 1'b1;
    step();
    spi_valid = 1'b0;
    clear     = 1'b0;
    check("set_wins", overflow, 1);
    check("set_wins_level", level, DEPTH);
    force_busy = 1'b0;
    wait_idle("setwin_drain", 1000);

    // Busy never rises: timeout returns to IDLE, next byte follows
    uart_mute = 1'b1;
    t0 = trig_count;
    push(SRC_WIDTH'($urandom), 1'b1);
    push(SRC_WIDTH'($urandom), 1'b1);
    for (int i = 0; i < 40 && trig_count < t0 + 2; i++) step();
    check("timeout_two_triggers", trig_count - t0, 2);
    if (trig_cyc.size() >= 2) begin
      sp = trig_cyc[$] - trig_cyc[$-1];
      n_checks++;
      if (sp < BUSY_TIMEOUT + 1 || sp > BUSY_TIMEOUT + 2) begin
        n_fail++;
        $display("FAIL timeout_gap: got %0d cycles expected %0d..%0d", sp, BUSY_TIMEOUT + 1, BUSY_TIMEOUT + 2);
      end
    end
    wait_idle("timeout_drain", 200);
    uart_mute = 1'b0;

    // Enable drop with one byte in flight and five queued
    uart_len = 20;
    t0 = trig_count;
    for (int i = 0; i < 6; i++) push(SRC_WIDTH'($urandom), 1'b1);
    check("en_level_before", level, 5);
    enable = 1'b0;
    step();
    exp_q.delete();
    check("en_flush_level", level, 0);
    t1 = trig_count;
    check("en_inflight", t1 - t0, 1);
    repeat (40) step();
    check("en_no_more_trig", trig_count, t1);
    d = SRC_WIDTH'($urandom);
    push(d, 1'b0);
    check("en_sample_updates", sample, slice_of(d));
    check("en_level_stays", level, 0);
    wait_idle("en_drain", 200);
    enable = 1'b1;

    // Reset in the middle of traffic
    uart_len = 5;
    for (int i = 0; i < 3; i++) push(SRC_WIDTH'($urandom), 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_uart_data", uart_data, 0);
    check("midrst_trigger", trig, 0);
    check("midrst_sample", sample, 0);
    check("midrst_level", level, 0);
    check("midrst_overflow", overflow, 0);
    step();
    step();
    rst_n = 1'b1;
    t0 = trig_count;
    repeat (30) step();
    check("midrst_no_trig", trig_count, t0);
    check("midrst_level_after", level, 0);
    push(SRC_WIDTH'($urandom), 1'b1);
    wait_idle("midrst_new_push", 200);
    check("midrst_one_trig", trig_count - t0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_uart_bridge.md
# sample_uart_bridge

Buffers 8-bit audio samples from the ADC SPI controller and streams them to the UART transmitter under its busy handshake. It sits between `spi_con` (upstream) and `uart_transmit` (downstream). It replaces ad-hoc "sample waiting" logic with a small FIFO, so bytes are not lost when a UART frame overlaps the next 8 kHz sample. It also holds the most recent sample for the PWM line-out path.

## Interface
Parameters:
- `SRC_WIDTH`, 17: width of the SPI read word.
- `SAMPLE_LSB`, 2: the sample is `spi_data_in[SAMPLE_LSB+7:SAMPLE_LSB]`.
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `BUSY_TIMEOUT`, 4: cycles to wait for `uart_busy_in` to rise after a trigger.

Ports (one clock; reset is asynchronous and active-low):
- `clk_in` in 1: system clock, 100 MHz.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `enable_in` in 1: streaming enable (sw[0]).
- `clear_in` in 1: synchronous clear of `overflow_out`.
- `spi_data_in` in SRC_WIDTH: SPI read word.
- `spi_valid_in` in 1: single-cycle valid for `spi_data_in`.
- `uart_busy_in` in 1: `uart_transmit` busy.
- `uart_data_out` out 8: byte presented to the UART.
- `uart_trigger_out` out 1: single-cycle send strobe.
- `sample_out` out 8: last captured sample, regardless of `enable_in`.
- `level_out` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow_out` out 1: sticky flag, set when a sample is dropped because the FIFO is full.

## Operation
- **Capture.**
  - On `spi_valid_in`, `sample_out` ← slice. This happens always, including when `enable_in` is low.
  - If `enable_in` is also high, the slice is pushed to the FIFO.
- **Push/pop arbitration.**
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and `overflow_out` ← 1.
  - Simultaneous push and pop leaves `level_out` unchanged.
- **`enable_in` low.**
  - Read pointer ← write pointer and `level_out` ← 0 on the next edge (flush).
  - A byte already triggered completes normally.
- **`clear_in`.** Clears `overflow_out`. If an overflow occurs in the same cycle, set wins.
- **FSM states.**
  - IDLE: if FIFO non-empty, `enable_in` high and `uart_busy_in` low → pop head into `uart_data_out`, pulse `uart_trigger_out`, go to ARM.
  - ARM: counter counts cycles.
    - `uart_busy_in` high → SEND.
    - Counter reaches BUSY_TIMEOUT → IDLE. The byte counts as sent.
  - SEND: `uart_busy_in` low → IDLE.
- **Pointers.** Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - Full: MSBs differ and the remaining bits are equal.
  - Empty: pointers are equal.

## Timing
- **Reset values.** All outputs are 0; FSM is in IDLE; pointers are 0. Reset acts immediately, mid-frame included. The pending FIFO contents are lost.
- **Capture and push latency.**
  - `sample_out` and `level_out` update on the edge after `spi_valid_in`.
  - The earliest trigger is 1 cycle after the push is visible (`level_out` ≥ 1 in IDLE).
- **Trigger output.**
  - `uart_trigger_out` is high for exactly one cycle.
  - `uart_data_out` is valid in that cycle and is held until the next trigger.
- **Trigger spacing.** Back-to-back triggers are separated by at least one cycle of `uart_busy_in` low observed in IDLE.
- **Throughput.** One byte per UART frame (~86.8 µs at 115200 baud). Sustained 8 kHz input never overflows.

## Structure
- Package `audio_bridge_pkg`:
  - FSM enum `bridge_state_t` {IDLE, ARM, SEND}.
  - `SAMPLE_W = 8`.
- Sub-module `sync_fifo`: parameterised WIDTH/DEPTH, push/pop/full/empty/level, same clock and reset.
- The FSM and capture logic live in the top of the block.

## Test plan
- **Reset.** Reset with traffic in flight → all outputs 0; no trigger until a new push.
- **Single sample.** `spi_data_in` = 17'h003FC, valid, enable = 1, UART model with busy 3 cycles after trigger → `sample_out` = 8'hFF, one trigger with `uart_data_out` = 8'hFF, `level_out` returns to 0.
- **Overflow.** Busy held high and 17 pushes with DEPTH = 16 → `level_out` = 16, `overflow_out` = 1. Release busy → 16 bytes emitted in push order. `clear_in` → `overflow_out` = 0.
- **Simultaneous push/pop at full.** Push and pop in the same cycle → push accepted, no overflow, `level_out` stays 16.
- **Busy timeout.** `uart_busy_in` never rises → FSM returns to IDLE after 4 cycles; the next byte is triggered afterwards.
- **Enable drop.** `enable_in` falls with 5 queued and one in flight → in-flight byte completes, `level_out` = 0, no further triggers. `sample_out` still updates on later valids.
